line_bridge: RTL and testbench

//  Single-line write-back buffer directly downstream of the CPU memory port.

---
 rtl/rv32i_types.sv | 29 ++
 rtl/line_bridge_line_store.sv | 47 ++++
 rtl/line_bridge.sv | 152 +++++++++++++++
 tb/tb_line_bridge.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types and sizing for the single-line write-back bridge.
package rv32i_types;

  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned LINE_WIDTH       = 256;
  localparam int unsigned BEAT_WIDTH       = 64;
  localparam int unsigned WORD_WIDTH       = 32;
  localparam int unsigned BE_WIDTH         = WORD_WIDTH / 8;
  localparam int unsigned LINE_OFFSET_BITS = 5;
  localparam int unsigned BEATS            = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned BEAT_IDX_BITS    = $clog2(BEATS);
  localparam int unsigned WORDS            = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned WORD_IDX_BITS    = $clog2(WORDS);
  localparam int unsigned BYTE_OFF_BITS    = LINE_OFFSET_BITS - WORD_IDX_BITS;
  localparam int unsigned TAG_WIDTH        = ADDR_WIDTH - LINE_OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} line_bridge_state_t;

  // CPU byte address split into line tag, word-in-line and byte-in-word.
  typedef struct packed {
    logic [TAG_WIDTH-1:0]     tag;
    logic [WORD_IDX_BITS-1:0] word;
    logic [BYTE_OFF_BITS-1:0] byte_off;
  } cpu_addr_t;

  typedef logic [WORDS-1:0][WORD_WIDTH-1:0] line_words_t;
  typedef logic [BEATS-1:0][BEAT_WIDTH-1:0] line_beats_t;

endpackage

// File: rtl/line_bridge_line_store.sv
// Line data storage: byte-merged word writes, burst beat writes, word and beat read muxes.
module line_bridge_line_store
  import rv32i_types::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     word_we,
  input  logic [WORD_IDX_BITS-1:0] word_idx,
  input  logic [BE_WIDTH-1:0]      byte_enable,
  input  logic [WORD_WIDTH-1:0]    word_wdata,
  input  logic                     beat_we,
  input  logic [BEAT_IDX_BITS-1:0] beat_wr_idx,
  input  logic [BEAT_WIDTH-1:0]    beat_wdata,
  input  logic [BEAT_IDX_BITS-1:0] beat_rd_idx,
  output logic [WORD_WIDTH-1:0]    word_rdata_c,
  output logic [WORD_WIDTH-1:0]    merged_word_c,
  output logic [BEAT_WIDTH-1:0]    beat_rdata_c
);

  line_beats_t data;
  line_beats_t data_next;
  line_words_t words;
  line_words_t words_next;

  assign words        = data;
  assign word_rdata_c = words[word_idx];
  assign beat_rdata_c = data[beat_rd_idx];

  // Byte-lane merge of CPU write data over the currently stored word.
  for (genvar b = 0; b < BE_WIDTH; b++) begin : g_merge
    assign merged_word_c[b*8 +: 8] = byte_enable[b] ? word_wdata[b*8 +: 8]
                                                    : word_rdata_c[b*8 +: 8];
  end

  always_comb begin
    words_next = words;
    if (word_we) words_next[word_idx] = merged_word_c;
    data_next = words_next;
    if (beat_we) data_next[beat_wr_idx] = beat_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data <= '0;
    else      data <= data_next;
  end

endmodule

// File: rtl/line_bridge.sv
// Single-line write-back buffer between the CPU memory port and burst physical memory.
module line_bridge
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [BE_WIDTH-1:0]   mem_byte_enable,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [BEAT_WIDTH-1:0] pmem_wdata,
  input  logic [BEAT_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  line_bridge_state_t state, state_next;

  logic                     valid, valid_next;
  logic                     dirty, dirty_next;
  logic [TAG_WIDTH-1:0]     tag, tag_next;
  logic [BEAT_IDX_BITS-1:0] counter, counter_next;
  logic                     word_we, beat_we, rdata_load;
  logic [ADDR_WIDTH-1:0]    pmem_address_next;
  logic [WORD_WIDTH-1:0]    word_rdata_c, merged_word_c;
  logic [BEAT_WIDTH-1:0]    beat_rdata_c;
  logic                     req, hit, last_beat;
  cpu_addr_t                req_addr;
  logic [BYTE_OFF_BITS-1:0] unused_byte_off;

  assign req_addr        = mem_address;
  assign unused_byte_off = req_addr.byte_off;
  assign req             = mem_read | mem_write;
  assign hit             = valid && (tag == req_addr.tag);
  assign last_beat       = (counter == BEAT_IDX_BITS'(BEATS - 1));

  line_bridge_line_store u_line_store (
    .clk           (clk),
    .rst           (rst),
    .word_we       (word_we),
    .word_idx      (req_addr.word),
    .byte_enable   (mem_byte_enable),
    .word_wdata    (mem_wdata),
    .beat_we       (beat_we),
    .beat_wr_idx   (counter),
    .beat_wdata    (pmem_rdata),
    .beat_rd_idx   (counter_next),
    .word_rdata_c  (word_rdata_c),
    .merged_word_c (merged_word_c),
    .beat_rdata_c  (beat_rdata_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state plus line bookkeeping; a write with both request lines high is a write.
  always_comb begin
    state_next   = state;
    valid_next   = valid;
    dirty_next   = dirty;
    tag_next     = tag;
    counter_next = counter;
    word_we      = 1'b0;
    beat_we      = 1'b0;
    rdata_load   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_next = RESP;
            rdata_load = 1'b1;
            if (mem_write) begin
              word_we = 1'b1;
              if (mem_byte_enable != '0) dirty_next = 1'b1;
            end
          end else if (valid && dirty) begin
            state_next = WB;
          end else begin
            state_next = FILL;
          end
        end
      end
      WB: begin
        if (pmem_resp) begin
          counter_next = last_beat ? '0 : counter + BEAT_IDX_BITS'(1);
          if (last_beat) begin
            dirty_next = 1'b0;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (pmem_resp) begin
          beat_we      = 1'b1;
          counter_next = last_beat ? '0 : counter + BEAT_IDX_BITS'(1);
          if (last_beat) begin
            tag_next   = req_addr.tag;
            valid_next = 1'b1;
            dirty_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pmem_address_next = '0;
    case (state_next)
      WB:      pmem_address_next = {tag, {LINE_OFFSET_BITS{1'b0}}};
      FILL:    pmem_address_next = {req_addr.tag, {LINE_OFFSET_BITS{1'b0}}};
      default: pmem_address_next = '0;
    endcase
  end

  // Outputs are registered from next-state decode so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid        <= 1'b0;
      dirty        <= 1'b0;
      tag          <= '0;
      counter      <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      valid        <= valid_next;
      dirty        <= dirty_next;
      tag          <= tag_next;
      counter      <= counter_next;
      mem_resp     <= (state_next == RESP);
      pmem_read    <= (state_next == FILL);
      pmem_write   <= (state_next == WB);
      pmem_address <= pmem_address_next;
      pmem_wdata   <= (state_next == WB) ? beat_rdata_c : '0;
      if (rdata_load) mem_rdata <= mem_write ? merged_word_c : word_rdata_c;
    end
  end

endmodule

// File: tb/tb_line_bridge.sv
// Bench for line_bridge: directed vector table, stall and reset sequences, randomized ops vs a flat-memory model.
module tb_line_bridge;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_address = '0, mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp, pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;

  line_bridge dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
  } burst_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_cyc;
    logic [31:0] exp_wb;
    logic [31:0] exp_fill;
  } vec_t;

  int n_checks = 0, n_pass = 0, n_ops = 0;
  int resp_pulses = 0, overlap = 0;
  int stall_min = 0, stall_max = 0, beat_limit = BEATS, beats_given = 0, cur_kind = 0;
  burst_t burst_log[$];
  logic [63:0] pmem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  bit          model_valid = 0, model_dirty = 0;
  logic [26:0] model_tag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] pat(input int unsigned ba);
    logic [31:0] a;
    a = 32'(ba);
    return {a * 32'h9E37_79B1, a ^ 32'h5A5A_1234};
  endfunction

  function automatic logic [63:0] mem_get(input int unsigned ba);
    if (pmem.exists(ba)) return pmem[ba];
    return pat(ba);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    logic [63:0] b;
    if (ref_mem.exists(int'(a >> 2))) return ref_mem[int'(a >> 2)];
    b = pat(a >> 3);
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  // Physical memory: one pmem_resp per beat after a stall drawn from [stall_min, stall_max].
  initial begin : responder
    int wait_n, kind;
    int unsigned base;
    wait_n = -1;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      kind = pmem_write ? 2 : (pmem_read ? 1 : 0);
      if (kind != cur_kind) begin
        cur_kind = kind; beats_given = 0; wait_n = -1;
        if (kind != 0) burst_log.push_back('{kind == 2, pmem_address});
      end
      if (kind != 0 && beats_given < beat_limit) begin
        if (wait_n < 0) wait_n = int'($urandom_range(stall_max, stall_min));
        if (wait_n == 0) begin
          base = int'(pmem_address >> 3) + beats_given;
          if (kind == 2) pmem[base] = pmem_wdata;
          else pmem_rdata = mem_get(base);
          pmem_resp = 1'b1;
          beats_given++;
          wait_n = -1;
        end else begin
          wait_n--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (pmem_read && pmem_write) overlap++;
    if (mem_resp) resp_pulses++;
  end

  // Issue one request at posedge+1, wait for mem_resp, then spend one cycle idle.
  task automatic cpu_op(input bit rd_line, input bit wr_line, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    mem_read = rd_line; mem_write = wr_line; mem_address = addr;
    mem_byte_enable = be; mem_wdata = wd;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!mem_resp && cyc < 400);
    if (!mem_resp) begin
      n_checks++;
      $display("FAIL op%0d_timeout: no mem_resp after %0d cycles", n_ops, cyc);
    end else begin
      n_ops++;
    end
    rd = mem_rdata;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reference: the bridge must look like flat memory with one resident line.
  task automatic model_op(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] exp_rd,
                          output bit exp_hit, output logic [31:0] exp_wb);
    logic [31:0] w;
    exp_hit = model_valid && (model_tag == addr[31:5]);
    exp_wb  = (!exp_hit && model_valid && model_dirty) ? {model_tag, 5'b0} : NONE;
    if (!exp_hit) begin model_valid = 1; model_tag = addr[31:5]; model_dirty = 0; end
    w = ref_get(addr);
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      ref_mem[int'(addr >> 2)] = w;
      if (be != 4'h0) model_dirty = 1;
    end
    exp_rd = w;
  endtask

  task automatic check_bursts(input string pfx, input logic [31:0] wb, input logic [31:0] fill);
    burst_t exp_q[$];
    if (wb != NONE) exp_q.push_back('{1'b1, wb});
    if (fill != NONE) exp_q.push_back('{1'b0, fill});
    check({pfx, "_bursts"}, 64'(burst_log.size()), 64'(exp_q.size()));
    if (burst_log.size() == exp_q.size())
      foreach (exp_q[j]) check($sformatf("%s_burst%0d", pfx, j),
                               {31'b0, burst_log[j].is_wr, burst_log[j].addr},
                               {31'b0, exp_q[j].is_wr, exp_q[j].addr});
  endtask

  task automatic checked_op(input bit rd_too, input bit wr, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd, output int cyc);
    logic [31:0] e_rd, rd, e_wb;
    bit e_hit;
    string pfx;
    pfx = $sformatf("op%0d", n_ops);
    model_op(wr, addr, be, wd, e_rd, e_hit, e_wb);
    burst_log.delete();
    cpu_op(rd_too || !wr, wr, addr, be, wd, rd, cyc);
    check({pfx, "_rdata"}, 64'(rd), 64'(e_rd));
    if (e_hit) check({pfx, "_hit_latency"}, 64'(cyc), 64'd1);
    check_bursts(pfx, e_wb, e_hit ? NONE : {addr[31:5], 5'b0});
  endtask

  vec_t vecs[8];

  initial begin : main
    logic [63:0] p8, p9, p11, p208;
    logic [31:0] merged, rd, a;
    int cyc, cnt, snap;
    logic [31:0] lines[5];

    p8 = pat(8); p9 = pat(9); p11 = pat(11); p208 = pat(32'h208);
    merged = {p9[31:16], 16'hBEEF};
    vecs[0] = '{0, 32'h40,   4'h0, 32'h0,         p8[31:0],   BEATS + 2,     NONE,  32'h40};
    vecs[1] = '{0, 32'h5C,   4'h0, 32'h0,         p11[63:32], 1,             NONE,  NONE};
    vecs[2] = '{1, 32'h48,   4'h3, 32'hDEAD_BEEF, merged,     1,             NONE,  NONE};
    vecs[3] = '{0, 32'h48,   4'h0, 32'h0,         merged,     1,             NONE,  NONE};
    vecs[4] = '{0, 32'h1040, 4'h0, 32'h0,         p208[31:0], 2 * BEATS + 2, 32'h40, 32'h1040};
    vecs[5] = '{0, 32'h48,   4'h0, 32'h0,         merged,     BEATS + 2,     NONE,  32'h40};
    vecs[6] = '{1, 32'h4C,   4'h0, 32'hFFFF_FFFF, p9[63:32],  1,             NONE,  NONE};
    vecs[7] = '{0, 32'h1040, 4'h0, 32'h0,         p208[31:0], BEATS + 2,     NONE,  32'h1040};

    // Reset values
    #12;
    check("rst_mem_resp", 64'(mem_resp), 64'd0);
    check("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    check("rst_pmem_read", 64'(pmem_read), 64'd0);
    check("rst_pmem_write", 64'(pmem_write), 64'd0);
    check("rst_pmem_address", 64'(pmem_address), 64'd0);
    check("rst_pmem_wdata", pmem_wdata, 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // Directed table with a zero-wait memory
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e_rd, e_wb;
      bit e_hit;
      model_op(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, e_rd, e_hit, e_wb);
      burst_log.delete();
      cpu_op(!vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, rd, cyc);
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
      check_bursts($sformatf("vec%0d", i), vecs[i].exp_wb, vecs[i].exp_fill);
    end
    check("wb_beat1_merged", pmem[9], {p9[63:32], merged});

    // Three idle cycles ahead of every fill beat
    stall_min = 3; stall_max = 3;
    checked_op(0, 0, 32'h2000, 4'h0, 32'h0, cyc);
    check("stall_fill_cycles", 64'(cyc), 64'(BEATS * 4 + 2));
    checked_op(0, 0, 32'h2018, 4'h0, 32'h0, cyc);
    stall_min = 0; stall_max = 0;

    // Reset in the middle of a fill after two beats
    beat_limit = 2;
    mem_read = 1'b1; mem_address = 32'h40;
    cnt = 0;
    while (!(cur_kind == 1 && beats_given == 2) && cnt < 50) begin @(negedge clk); cnt++; end
    check("midfill_beats", 64'(beats_given), 64'd2);
    @(posedge clk); #3;
    check("midfill_pmem_read", 64'(pmem_read), 64'd1);
    snap = resp_pulses;
    rst = 1'b0;
    #1;
    check("midfill_rst_pmem_read", 64'(pmem_read), 64'd0);
    check("midfill_rst_pmem_address", 64'(pmem_address), 64'd0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("midfill_no_resp", 64'(resp_pulses), 64'(snap));
    model_valid = 0; model_dirty = 0;
    beat_limit = BEATS;
    checked_op(0, 0, 32'h40, 4'h0, 32'h0, cyc);

    // Randomized traffic with stalling memory
    lines = '{32'h40, 32'h1040, 32'h2000, 32'h60, 32'hFFFF_FFE0};
    stall_max = 2;
    for (int i = 0; i < 250; i++) begin
      a = lines[$urandom_range(4, 0)] | (32'($urandom_range(7, 0)) << 2) | 32'($urandom_range(3, 0));
      checked_op(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), a,
                 4'($urandom_range(15, 0)), $urandom, cyc);
    end

    @(negedge clk);
    check("no_rw_overlap", 64'(overlap), 64'd0);
    check("resp_pulse_count", 64'(resp_pulses), 64'(n_ops));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
